// File: rtl/swap_pair_pipe.sv
// ---------------------------------------------------------------------------
// swap_pair_pipe
//   Two-stage valid/ready pipeline that takes an operand pair (a, b) and
//   delivers it unchanged, exchanged, or compare-exchanged into order.
//   Both result operands are written from one registered snapshot on the
//   same edge, so a result never carries the same operand twice.
//
//   Ports
//     clk, rst_n          : rising-edge clock, async active-low reset
//     in_valid/in_ready   : upstream handshake
//     in_a, in_b          : operand pair
//     in_mode             : 00 pass, 01 swap, 10 compare-swap, 11 pass
//     out_valid/out_ready : downstream handshake
//     out_x, out_y        : result pair
//     out_swapped         : result is exchanged relative to (in_a, in_b)
//     cnt_clr             : synchronous clear of swap_cnt
//     swap_cnt            : saturating count of delivered swapped results
// ---------------------------------------------------------------------------
module swap_pair_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter bit          SIGNED  = 1'b0,
  parameter bit          DESCEND = 1'b0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             out_swapped,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] swap_cnt
);

  localparam logic [1:0] MODE_SWAP = 2'b01;
  localparam logic [1:0] MODE_CMP  = 2'b10;

  // stage 1 snapshot
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [1:0]       r_s1_mode;
  logic             r_s1_gt;
  logic             r_s1_lt;

  // stage 2 / output registers
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_sw;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_gt;
  logic             w_lt;
  logic             w_cmp;
  logic             w_swap;
  logic             w_out_xfer;
  logic             w_cnt_sat;

  // Flow control: a stage may take new data when it is empty or when the
  // stage after it is moving.  in_ready therefore sees out_ready
  // combinationally, which lets a full pipe stream one pair per cycle.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Both orderings are resolved in stage 1 so stage 2 only muxes.
  // With a == b both flags are 0, so compare mode never swaps equal values.
  assign w_gt = SIGNED ? ($signed(in_a) > $signed(in_b)) : (in_a > in_b);
  assign w_lt = SIGNED ? ($signed(in_b) > $signed(in_a)) : (in_b > in_a);

  // DESCEND wants the larger value on out_x, i.e. swap when b > a.
  assign w_cmp  = DESCEND ? r_s1_lt : r_s1_gt;
  assign w_swap = (r_s1_mode == MODE_SWAP) || ((r_s1_mode == MODE_CMP) && w_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= '0;
      r_s1_gt    <= 1'b0;
      r_s1_lt    <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_s1_mode <= in_mode;
        r_s1_gt   <= w_gt;
        r_s1_lt   <= w_lt;
      end
    end
  end

  // Result registers only change on advance, so data holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_sw       <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_x  <= w_swap ? r_s1_b : r_s1_a;
        r_y  <= w_swap ? r_s1_a : r_s1_b;
        r_sw <= w_swap;
      end
    end
  end

  assign w_out_xfer = r_s2_valid && out_ready;
  assign w_cnt_sat  = &r_cnt;

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_out_xfer && r_sw && !w_cnt_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_x       = r_x;
  assign out_y       = r_y;
  assign out_swapped = r_sw;
  assign swap_cnt    = r_cnt;

endmodule

// File: tb/tb_swap_pair_pipe.sv
// ---------------------------------------------------------------------------
// tb_swap_pair_pipe
//   Three instances share one stimulus stream:
//     d0: unsigned, ascending   d1: signed, ascending   d2: unsigned, descending
//   All use a 4-bit swap counter. A negedge monitor keeps a scoreboard of
//   expected results per instance and a model of each swap counter; the
//   scenario tasks add targeted inline checks on top.
// ---------------------------------------------------------------------------
module tb_swap_pair_pipe;
  localparam int W = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [1:0]    in_mode = '0;
  logic          out_ready = 1'b1;
  logic          cnt_clr = 1'b0;

  logic [2:0]    in_ready;
  logic [2:0]    out_valid;
  logic [2:0]    out_sw;
  logic [W-1:0]  out_x [3];
  logic [W-1:0]  out_y [3];
  logic [CW-1:0] cnt [3];

  int n_total = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0][W-1:0] x;
    logic [2:0][W-1:0] y;
    logic [2:0]        sw;
  } exp_t;

  exp_t          q[$];
  logic [CW-1:0] mcnt [3];

  always #5 clk = ~clk;

  swap_pair_pipe #(.WIDTH(W), .SIGNED(1'b0), .DESCEND(1'b0), .CNT_W(CW)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_x(out_x[0]), .out_y(out_y[0]),
    .out_swapped(out_sw[0]), .cnt_clr(cnt_clr), .swap_cnt(cnt[0]));

  swap_pair_pipe #(.WIDTH(W), .SIGNED(1'b1), .DESCEND(1'b0), .CNT_W(CW)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_x(out_x[1]), .out_y(out_y[1]),
    .out_swapped(out_sw[1]), .cnt_clr(cnt_clr), .swap_cnt(cnt[1]));

  swap_pair_pipe #(.WIDTH(W), .SIGNED(1'b0), .DESCEND(1'b1), .CNT_W(CW)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid[2]),
    .out_ready(out_ready), .out_x(out_x[2]), .out_y(out_y[2]),
    .out_swapped(out_sw[2]), .cnt_clr(cnt_clr), .swap_cnt(cnt[2]));

  // Reference behaviour of one configuration.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] m, input bit s, input bit d,
                                output logic [W-1:0] x, output logic [W-1:0] y,
                                output logic sw);
    bit a_gt_b, b_gt_a;
    a_gt_b = s ? ($signed(a) > $signed(b)) : (a > b);
    b_gt_a = s ? ($signed(b) > $signed(a)) : (b > a);
    sw = (m == 2'b01) || ((m == 2'b10) && (d ? b_gt_a : a_gt_b));
    x  = sw ? b : a;
    y  = sw ? a : b;
  endfunction

  // Scoreboard monitor: inputs are stable from posedge+1 to the next posedge,
  // so handshakes seen here are the ones the next edge will complete.
  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] mx, my;
    logic msw;
    bit xfer;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (cnt[k] !== mcnt[k]) begin
          n_bad++;
          $display("FAIL swap_cnt d%0d got=%0d exp=%0d t=%0t", k, cnt[k], mcnt[k], $time);
        end
      end
      e = '0;
      xfer = out_valid[0] && out_ready;
      if (xfer) begin
        n_total++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output got x=%h y=%h exp=none t=%0t", out_x[0], out_y[0], $time);
          xfer = 1'b0;
        end else begin
          e = q.pop_front();
          for (int k = 0; k < 3; k++) begin
            n_total++;
            if (out_valid[k] !== 1'b1 || out_x[k] !== e.x[k] || out_y[k] !== e.y[k] || out_sw[k] !== e.sw[k]) begin
              n_bad++;
              $display("FAIL sb_result d%0d got=(%h,%h,%b,v%b) exp=(%h,%h,%b) t=%0t", k,
                       out_x[k], out_y[k], out_sw[k], out_valid[k], e.x[k], e.y[k], e.sw[k], $time);
            end
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (cnt_clr) mcnt[k] = '0;
        else if (xfer && e.sw[k] && mcnt[k] != '1) mcnt[k] = mcnt[k] + 1'b1;
      end
      if (in_valid && in_ready[0]) begin
        model(in_a, in_b, in_mode, 1'b0, 1'b0, mx, my, msw); e.x[0] = mx; e.y[0] = my; e.sw[0] = msw;
        model(in_a, in_b, in_mode, 1'b1, 1'b0, mx, my, msw); e.x[1] = mx; e.y[1] = my; e.sw[1] = msw;
        model(in_a, in_b, in_mode, 1'b0, 1'b1, mx, my, msw); e.x[2] = mx; e.y[2] = my; e.sw[2] = msw;
        q.push_back(e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
  endtask

  // Send one pair into an idle pipe with out_ready high and stop on the
  // negedge where its result is presented.
  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
    @(posedge clk); #1 drive(a, b, m);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8 && !out_valid[0]; i++) @(negedge clk);
    n_total++;
    if (!out_valid[0]) begin
      n_bad++;
      $display("FAIL send_one_timeout got=out_valid0 exp=out_valid1");
    end
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid[0]); i++) @(negedge clk);
    n_total++;
    if (q.size() != 0 || out_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain got=pending%0d exp=pending0", name, q.size());
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) mcnt[k] = '0;
    #3;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (out_valid[k] !== 1'b0 || out_x[k] !== '0 || out_y[k] !== '0 || out_sw[k] !== 1'b0 || cnt[k] !== '0) begin
        n_bad++;
        $display("FAIL reset_state d%0d got=(v%b,%h,%h,%b,%0d) exp=(v0,0,0,0,0)", k,
                 out_valid[k], out_x[k], out_y[k], out_sw[k], cnt[k]);
      end
    end
    #9 rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_in_ready got=%b exp=111", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    pulse_clr();
    drive(32'd1, 32'd2, 2'b00);
    @(posedge clk); #1 drive(32'd1, 32'd2, 2'b01);
    @(posedge clk); #1 drive(32'd7, 32'd3, 2'b10);
    @(negedge clk);
    n_total++;
    if ({out_valid[0], out_x[0], out_y[0], out_sw[0]} !== {1'b1, 32'd1, 32'd2, 1'b0}) begin
      n_bad++; $display("FAIL basic_pass got=(v%b,%0d,%0d,%b) exp=(v1,1,2,0)", out_valid[0], out_x[0], out_y[0], out_sw[0]);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({out_valid[0], out_x[0], out_y[0], out_sw[0]} !== {1'b1, 32'd2, 32'd1, 1'b1}) begin
      n_bad++; $display("FAIL basic_swap got=(v%b,%0d,%0d,%b) exp=(v1,2,1,1)", out_valid[0], out_x[0], out_y[0], out_sw[0]);
    end
    @(negedge clk);
    n_total++;
    if ({out_valid[0], out_x[0], out_y[0], out_sw[0]} !== {1'b1, 32'd3, 32'd7, 1'b1}) begin
      n_bad++; $display("FAIL basic_cmp got=(v%b,%0d,%0d,%b) exp=(v1,3,7,1)", out_valid[0], out_x[0], out_y[0], out_sw[0]);
    end
    @(negedge clk);
    n_total++;
    if (cnt[0] !== 4'd2) begin
      n_bad++; $display("FAIL basic_cnt got=%0d exp=2", cnt[0]);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1 out_ready = 1'b0; drive(32'd10, 32'd20, 2'b00);
    @(posedge clk); #1 drive(32'd30, 32'd40, 2'b00);
    @(posedge clk); #1 drive(32'd50, 32'd60, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || out_x[0] !== 32'd10 || out_y[0] !== 32'd20) begin
        n_bad++;
        $display("FAIL bp_hold got=(rdy%b,v%b,%0d,%0d) exp=(rdy0,v1,10,20)", in_ready[0], out_valid[0], out_x[0], out_y[0]);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready[0] !== 1'b1) begin
      n_bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready[0]);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain("bp");
  endtask

  task automatic test_signed();
    send_one(32'h8000_0000, 32'h0000_0001, 2'b10);
    n_total++;
    if ({out_x[1], out_sw[1]} !== {32'h8000_0000, 1'b0}) begin
      n_bad++; $display("FAIL signed_cmp got=(%h,%b) exp=(80000000,0)", out_x[1], out_sw[1]);
    end
    n_total++;
    if ({out_x[0], out_sw[0]} !== {32'h0000_0001, 1'b1}) begin
      n_bad++; $display("FAIL unsigned_cmp got=(%h,%b) exp=(00000001,1)", out_x[0], out_sw[0]);
    end
  endtask

  task automatic test_desc_equal();
    send_one(32'd5, 32'd5, 2'b10);
    n_total++;
    if ({out_x[2], out_y[2], out_sw[2], out_sw[0]} !== {32'd5, 32'd5, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL equal_cmp got=(%0d,%0d,%b,%b) exp=(5,5,0,0)", out_x[2], out_y[2], out_sw[2], out_sw[0]);
    end
    send_one(32'd2, 32'd9, 2'b10);
    n_total++;
    if ({out_x[2], out_y[2], out_sw[2]} !== {32'd9, 32'd2, 1'b1}) begin
      n_bad++; $display("FAIL desc_cmp got=(%0d,%0d,%b) exp=(9,2,1)", out_x[2], out_y[2], out_sw[2]);
    end
    send_one(32'd4, 32'd3, 2'b11);
    n_total++;
    if ({out_x[0], out_y[0], out_sw[0]} !== {32'd4, 32'd3, 1'b0}) begin
      n_bad++; $display("FAIL mode11_pass got=(%0d,%0d,%b) exp=(4,3,0)", out_x[0], out_y[0], out_sw[0]);
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'h7fff_ffff;
      4: return 32'hffff_ffff;
      5: return W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = pick(); in_b = pick();
      in_mode = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1 drain("rand");
  endtask

  task automatic test_counter();
    pulse_clr();
    drive(32'd1, 32'd2, 2'b01);
    repeat (17) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (cnt[k] !== 4'd15) begin
        n_bad++; $display("FAIL cnt_saturate d%0d got=%0d exp=15", k, cnt[k]);
      end
    end
    pulse_clr();
    drive(32'd8, 32'd9, 2'b01);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    @(negedge clk);
    n_total++;
    if (cnt[0] !== 4'd0) begin
      n_bad++; $display("FAIL cnt_clr_priority got=%0d exp=0", cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    send_one(32'd1, 32'd2, 2'b01);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b0; drive(32'd11, 32'd12, 2'b01);
    @(posedge clk); #1 drive(32'd13, 32'd14, 2'b01);
    @(posedge clk); #1 in_valid = 1'b0;
    n_total++;
    if (cnt[0] == 4'd0 || out_valid[0] !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_setup got=(cnt%0d,v%b) exp=(cnt!=0,v1)", cnt[0], out_valid[0]);
    end
    #2 rst_n = 1'b0;
    q.delete();
    for (int k = 0; k < 3; k++) mcnt[k] = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (out_valid[k] !== 1'b0 || cnt[k] !== '0 || out_x[k] !== '0) begin
        n_bad++; $display("FAIL rst_mid_clear d%0d got=(v%b,cnt%0d,%h) exp=(v0,0,0)", k, out_valid[k], cnt[k], out_x[k]);
      end
    end
    @(posedge clk); #2 rst_n = 1'b1; out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 3'b111) begin
      n_bad++; $display("FAIL rst_mid_ready got=%b exp=111", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (out_valid !== 3'b000) begin
        n_bad++; $display("FAIL rst_mid_stale got=%b exp=000", out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_signed();
    test_desc_equal();
    test_random();
    test_counter();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/swap_pair_pipe.md
Name: swap_pair_pipe

Overview:
- Two-stage valid/ready pipeline. Each transaction carries an operand pair (a, b).
- Per transaction, the pair is passed through, unconditionally swapped, or compare-and-swapped into ordered form.
- Sits directly downstream of the operand-pair register stage and feeds sort and exchange consumers.
- Provides registered, race-free swapping: both outputs are updated from the same registered snapshot in the same edge.

Parameters:
- WIDTH, 32, operand width in bits.
- SIGNED, 0, 1 = compare operands as two's complement; 0 = unsigned.
- DESCEND, 0, compare mode only: 0 puts the smaller value on out_x; 1 puts the larger value on out_x.
- CNT_W, 16, width of the saturating swap counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, upstream pair valid.
- in_ready, output, 1, block can accept a pair this cycle.
- in_a, input, WIDTH, first operand.
- in_b, input, WIDTH, second operand.
- in_mode, input, 2, operation: 00 pass, 01 swap, 10 compare-swap, 11 treated as pass.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- out_x, output, WIDTH, first result operand.
- out_y, output, WIDTH, second result operand.
- out_swapped, output, 1, 1 if out_x/out_y are exchanged relative to in_a/in_b.
- cnt_clr, input, 1, synchronous clear of swap_cnt.
- swap_cnt, output, CNT_W, saturating count of delivered swapped results.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both stage valids clear; out_valid = 0.
  - out_x = 0, out_y = 0, out_swapped = 0, swap_cnt = 0.
  - in_ready = 1 as soon as reset deasserts.
- Handshakes:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - in_valid may be asserted regardless of in_ready.
  - Output data holds stable while out_valid && !out_ready.
- Stage 1 (S1):
  - Registers in_a, in_b and the mode.
  - Registers a compare flag gt: a > b, using a signed or unsigned compare per SIGNED.
- Stage 2 (S2): registers the result from the S1 snapshot:
  - swap = (mode==01) | (mode==10 & (DESCEND ? (b > a) : gt)).
  - out_x = swap ? b : a; out_y = swap ? a : b; out_swapped = swap.
  - Both outputs come from the same S1 registers, so the outputs never duplicate one operand.
- Flow control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (a combinational path from out_ready is permitted).
  - A stage loads when its advance condition holds.
  - A stage's valid clears when it advances with no incoming data.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to out_valid, with out_ready held high.
  - Throughput is 1 pair per cycle under continuous ready.
- Stalls:
  - With out_ready low, the block holds at most 2 pairs; then in_ready = 0.
  - No pair is dropped or duplicated.
- Equality: a == b in compare mode gives swap = 0.
- Signed compare (SIGNED = 1): 0x8000_0000 < 0x0000_0001.
- swap_cnt:
  - Increments by 1 on an output transfer with out_swapped = 1.
  - Saturates at 2^CNT_W - 1 and does not wrap.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Reset mid-operation:
  - All in-flight pairs are discarded.
  - No output transfer occurs after reset assertion.
- Mode 11 behaves exactly like pass.

Test Plan:
- Pass, swap and compare in sequence, with out_ready = 1:
  - Stimulus: pairs (1,2) mode 00, (1,2) mode 01, (7,3) mode 10.
  - Required outputs, two cycles after each input: (1,2,sw=0), (2,1,sw=1), (3,7,sw=1).
  - swap_cnt = 2.
- Backpressure:
  - Stimulus: out_ready = 0, stream pairs (10,20), (30,40), (50,60).
  - in_ready drops after 2 accepted; out_x/out_y hold 10/20 stable.
  - Release out_ready: results arrive in order with no loss.
- Signed vs unsigned compare:
  - Stimulus: (0x80000000, 0x00000001) in mode 10.
  - SIGNED = 1: out_x = 0x80000000, sw = 0.
  - SIGNED = 0: out_x = 0x00000001, sw = 1.
- Equal operands and DESCEND = 1:
  - Stimulus (5,5) mode 10: result (5,5), sw = 0.
  - Stimulus (2,9) mode 10: result (9,2), sw = 1.
- Counter saturation and clear:
  - Stimulus: CNT_W = 4, 17 swapped pairs.
  - swap_cnt stops at 15.
  - cnt_clr pulsed on the same cycle as a swapped delivery: swap_cnt = 0.
- Reset mid-stream:
  - Stimulus: assert rst_n = 0 asynchronously with 2 pairs in flight.
  - out_valid drops immediately; swap_cnt = 0.
  - After release, in_ready = 1 and no stale output appears.
